// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: single-cycle ALU ops plus a WIDTH-iteration shift-add
// signed multiplier, with a registered result and a Start/Busy/Done handshake.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kill,
  input  logic [3:0]       alucon,
  input  logic             shift,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_BLTZ = 4'b0011;
  localparam logic [3:0] OP_BGTZ = 4'b0100;
  localparam logic [3:0] OP_BLEZ = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_SLL  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FIX
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic               sign_reg;

  logic [WIDTH-1:0]   result_reg, hi_reg;
  logic               zero_reg, ovf_reg, done_reg;

  logic               is_mul;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic [WIDTH-1:0]   sum, diff;
  logic [4:0]         sh_amt;
  logic               a_pos;
  logic [2*WIDTH-1:0] fix_prod;

  assign is_mul = (alucon == OP_MUL);

  // An unsigned WIDTH-bit magnitude holds 2^(WIDTH-1), so the most-negative operand is exact.
  assign a_mag = a[MSB] ? (~a + 1'b1) : a;
  assign b_mag = b[MSB] ? (~b + 1'b1) : b;

  assign sum    = a + b;
  assign diff   = a - b;
  assign sh_amt = shift ? shamt : a[4:0];
  assign a_pos  = !a[MSB] && (a != '0);

  assign fix_prod = sign_reg ? (~acc_reg + 1'b1) : acc_reg;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alucon)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      OP_BLTZ: alu_res = {{(WIDTH-1){1'b0}}, a[MSB]};
      OP_BGTZ: alu_res = {{(WIDTH-1){1'b0}}, !a_pos};
      OP_BLEZ: alu_res = {{(WIDTH-1){1'b0}}, a_pos};
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = b << sh_amt;
      OP_SRL:  alu_res = b >> sh_amt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start && is_mul) state_next = ST_MUL;
      ST_MUL: begin
        if (kill)                               state_next = ST_IDLE;
        else if (cnt_reg == CW'(WIDTH - 1))     state_next = ST_FIX;
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      sign_reg   <= 1'b0;
      result_reg <= '0;
      hi_reg     <= '0;
      zero_reg   <= 1'b1;
      ovf_reg    <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            if (is_mul) begin
              mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
              mplier_reg <= b_mag;
              sign_reg   <= a[MSB] ^ b[MSB];
              acc_reg    <= '0;
              cnt_reg    <= '0;
            end else begin
              result_reg <= alu_res;
              hi_reg     <= '0;
              zero_reg   <= (alu_res == '0);
              ovf_reg    <= alu_ovf;
              done_reg   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 1'b1;
        end
        ST_FIX: begin
          // A killed multiply leaves the previous outputs untouched.
          if (!kill) begin
            result_reg <= fix_prod[WIDTH-1:0];
            hi_reg     <= fix_prod[2*WIDTH-1:WIDTH];
            zero_reg   <= (fix_prod[WIDTH-1:0] == '0);
            ovf_reg    <= 1'b0;
            done_reg   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign hi     = hi_reg;
  assign zero   = zero_reg;
  assign ovf    = ovf_reg;
  assign done   = done_reg;
  assign busy   = (state_reg != ST_IDLE);

endmodule
